// File: rtl/cache_line_arbiter_if.sv
// cache_line_arbiter_if: bundles the I-cache, D-cache and shared memory-port
// signals of the line-fill arbiter.
//   slave  : the arbiter's view (takes requests, drives the memory port)
//   master : the environment's view (requesters plus the memory model)
interface cache_line_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Shared memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: grants the shared line-fill memory port to either the
// I-cache or the D-cache, one transaction at a time. The granted address,
// write line and operation are captured at grant and held until mem_resp.
// Optional feature macro: CACHE_ARB_RR_EN
//   defined   -> round-robin between I and D on simultaneous requests
//   undefined -> fixed priority, D side always wins
module cache_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active-low
  cache_line_arbiter_if.slave  bus
);

  // Number of byte-offset bits inside one line.
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_q;        // 1 = line write, 0 = line read

  logic [ADDR_W-1:0] line_mask;
  logic [ADDR_W-1:0] i_addr_line;
  logic [ADDR_W-1:0] d_addr_line;
  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              grant_now;
  logic              busy;

  // Mask that clears the byte-offset bits of a line address.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_line_mask
      assign line_mask[gi] = (gi >= OFF_W);
    end
  endgenerate

  assign i_addr_line = bus.i_addr & line_mask;
  assign d_addr_line = bus.d_addr & line_mask;
  assign i_req       = bus.i_read;
  assign d_req       = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_RR_EN
  logic last_q;   // most recent grant: 0 = I, 1 = D

  // Round-robin: on a tie the side that was not granted last wins.
  always_comb begin
    pick_d = d_req && (!i_req || !last_q);
  end

  // Remember which side was granted most recently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else if (grant_now) begin
      last_q <= pick_d;
    end
  end
`else
  // Fixed priority: the D side wins every tie.
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Next-state and output decode; outputs depend only on registered state
  // except the response strobes, which follow mem_resp with zero latency.
  always_comb begin
    state_next    = state_q;
    busy          = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_next = GRANT_D;
        end else if (i_req) begin
          state_next = GRANT_I;
        end
      end
      GRANT_I: begin
        busy       = 1'b1;
        bus.i_resp = bus.mem_resp;
        if (bus.mem_resp) begin
          state_next = IDLE;
        end
      end
      GRANT_D: begin
        busy       = 1'b1;
        bus.d_resp = bus.mem_resp;
        if (bus.mem_resp) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (busy) begin
      bus.mem_read  = ~op_q;
      bus.mem_write = op_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
  end

  // A grant happens on the edge that leaves IDLE.
  assign grant_now = (state_q == IDLE) && (state_next != IDLE);

  // Returned line goes to both caches; only the granted side sees a resp.
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  // State register plus grant capture; captured fields stay frozen mid-grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_next;
      if (grant_now) begin
        addr_q  <= pick_d ? d_addr_line : i_addr_line;
        wdata_q <= bus.d_wdata;
        // Write-back beats fill when the D side asks for both at once.
        op_q    <= pick_d & bus.d_write;
      end
    end
  end

endmodule
